// File: rtl/cnt_pkg.sv
// Shared encodings for the prescaled counter family: counting modes and
// the ping-pong direction flag.
package cnt_pkg;

  typedef enum logic [1:0] {
    MODE_UP       = 2'b00,
    MODE_DOWN     = 2'b01,
    MODE_PINGPONG = 2'b10,
    MODE_HOLD     = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/tick_gen.sv
// Clock-enable prescaler: emits a one-cycle tick once every DIV enabled
// cycles. The count freezes while en is low, and clr restarts the interval.
module tick_gen #(
  parameter logic [31:0] DIV = 32'd50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [31:0] LAST = DIV - 32'd1;

  logic [31:0] pre_q;
  logic [31:0] pre_d;

  // With DIV=1, LAST is 0 and pre stays at 0, so tick simply follows en.
  assign tick = en && (pre_q == LAST);

  always_comb begin
    pre_d = pre_q;
    if (clr) begin
      pre_d = '0;
    end else if (tick) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = pre_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/prescaled_mode_counter.sv
// Modulo counter with up/down/ping-pong/hold modes that steps on a
// prescaled enable tick; load saturates to MODULUS-1 and restarts the interval.
module prescaled_mode_counter
  import cnt_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned DIV     = 50_000_000,
  parameter int unsigned MODULUS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] cnt,
  output logic             tick,
  output logic             wrap
);

  localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] CNT_MAX  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] CNT_MAX1 = WIDTH'(MODULUS - 2);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  dir_e             dir_q, dir_d;
  logic             pp_active_q, pp_active_d;
  logic             wrap_q, wrap_d;

  logic [WIDTH:0]   cnt_inc;
  logic [WIDTH:0]   cnt_dec;
  logic [WIDTH-1:0] din_sat;
  dir_e             pp_dir;

  tick_gen #(
    .DIV (32'(DIV))
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (load),
    .tick (tick)
  );

  assign cnt_inc = {1'b0, cnt_q} + {{WIDTH{1'b0}}, 1'b1};
  assign cnt_dec = {1'b0, cnt_q} - {{WIDTH{1'b0}}, 1'b1};
  assign din_sat = ({1'b0, din} < MOD_EXT) ? din : CNT_MAX;

  // A ping-pong step that does not follow another ping-pong step starts upward.
  assign pp_dir = pp_active_q ? dir_q : DIR_UP;

  always_comb begin
    cnt_d       = cnt_q;
    dir_d       = dir_q;
    pp_active_d = pp_active_q;
    wrap_d      = 1'b0;
    if (load) begin
      cnt_d = din_sat;
    end else if (tick) begin
      pp_active_d = 1'b0;
      unique case (mode_e'(mode))
        MODE_UP: begin
          if (cnt_inc >= MOD_EXT) begin
            cnt_d  = '0;
            wrap_d = 1'b1;
          end else begin
            cnt_d = cnt_inc[WIDTH-1:0];
          end
        end
        MODE_DOWN: begin
          if (cnt_q == '0) begin
            cnt_d  = CNT_MAX;
            wrap_d = 1'b1;
          end else begin
            cnt_d = cnt_dec[WIDTH-1:0];
          end
        end
        MODE_PINGPONG: begin
          pp_active_d = 1'b1;
          dir_d       = pp_dir;
          if (pp_dir == DIR_UP) begin
            if (cnt_inc >= MOD_EXT) begin
              dir_d  = DIR_DOWN;
              cnt_d  = CNT_MAX1;
              wrap_d = 1'b1;
            end else begin
              cnt_d = cnt_inc[WIDTH-1:0];
            end
          end else begin
            if (cnt_q == '0) begin
              dir_d  = DIR_UP;
              cnt_d  = {{(WIDTH-1){1'b0}}, 1'b1};
              wrap_d = 1'b1;
            end else begin
              cnt_d = cnt_dec[WIDTH-1:0];
            end
          end
        end
        default: begin
          cnt_d = cnt_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      dir_q       <= DIR_UP;
      pp_active_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      pp_active_q <= pp_active_d;
      wrap_q      <= wrap_d;
    end
  end

  assign cnt  = cnt_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_prescaled_mode_counter.sv
// Directed, table-driven bench for prescaled_mode_counter: a DIV=3/MODULUS=10
// instance for the mode sequences plus a DIV=1/MODULUS=16 instance.
module tb_prescaled_mode_counter;

  typedef struct {
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       load;
    logic [3:0] din;
    logic       e_tick;
    logic [3:0] e_cnt;
    logic       e_wrap;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, en, load;
  logic [1:0] mode;
  logic [3:0] din;
  logic [3:0] cnt;
  logic       tick, wrap;

  logic       en2, load2;
  logic [1:0] mode2;
  logic [3:0] din2;
  logic [3:0] cnt2;
  logic       tick2, wrap2;

  int total = 0;
  int bad   = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  prescaled_mode_counter #(.WIDTH(4), .DIV(3), .MODULUS(10)) dut (
    .clk (clk), .rst (rst), .en (en), .mode (mode), .load (load),
    .din (din), .cnt (cnt), .tick (tick), .wrap (wrap)
  );

  prescaled_mode_counter #(.WIDTH(4), .DIV(1), .MODULUS(16)) dut2 (
    .clk (clk), .rst (rst), .en (en2), .mode (mode2), .load (load2),
    .din (din2), .cnt (cnt2), .tick (tick2), .wrap (wrap2)
  );

  function automatic vec_t mk(input logic r, input logic e, input logic [1:0] m,
                              input logic l, input logic [3:0] d, input logic et,
                              input logic [3:0] ec, input logic ew);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.load = l; v.din = d;
    v.e_tick = et; v.e_cnt = ec; v.e_wrap = ew;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; load = 1'b0; mode = 2'b00; din = 4'd0; en2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    en  = 1'b1;
    #1;
    chk("reset cnt", 32'(cnt), 32'd0);
    chk("reset wrap", 32'(wrap), 32'd0);
    chk("reset tick", 32'(tick), 32'd0);
  endtask

  task automatic apply(input vec_t v, input string tag, input int idx);
    rst = v.rst; en = v.en; mode = v.mode; load = v.load; din = v.din;
    #1;
    chk($sformatf("%s[%0d] tick", tag, idx), 32'(tick), 32'(v.e_tick));
    @(posedge clk);
    #1;
    chk($sformatf("%s[%0d] cnt", tag, idx), 32'(cnt), 32'(v.e_cnt));
    chk($sformatf("%s[%0d] wrap", tag, idx), 32'(wrap), 32'(v.e_wrap));
    $display("%s[%0d] rst=%0b en=%0b mode=%0d load=%0b din=%0d -> cnt=%0d wrap=%0b",
             tag, idx, v.rst, v.en, v.mode, v.load, v.din, cnt, wrap);
  endtask

  task automatic run_vq(input string tag);
    foreach (vq[i]) apply(vq[i], tag, i);
    vq.delete();
  endtask

  initial begin
    int pp_seq[19] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 1};
    mode2 = 2'b00; load2 = 1'b0; din2 = 4'd0;

    // Up mode: one step per 3 cycles, 9->0 wrap after 30 cycles.
    do_reset();
    for (int i = 1; i <= 31; i++)
      vq.push_back(mk(0, 1, 2'b00, 0, 0, (i % 3) == 0, 4'((i / 3) % 10), i == 30));
    run_vq("up");

    // Down mode from reset.
    do_reset();
    vq.push_back(mk(0, 1, 2'b01, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 2'b01, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 2'b01, 0, 0, 1, 9, 1));
    vq.push_back(mk(0, 1, 2'b01, 0, 0, 0, 9, 0));
    vq.push_back(mk(0, 1, 2'b01, 0, 0, 0, 9, 0));
    vq.push_back(mk(0, 1, 2'b01, 0, 0, 1, 8, 0));
    vq.push_back(mk(0, 1, 2'b01, 0, 0, 0, 8, 0));
    vq.push_back(mk(0, 1, 2'b01, 0, 0, 0, 8, 0));
    vq.push_back(mk(0, 1, 2'b01, 0, 0, 1, 7, 0));
    run_vq("down");

    // Ping-pong from reset: 0..9..0..1, wrap on 9->8 and 0->1.
    do_reset();
    for (int i = 1; i <= 57; i++)
      vq.push_back(mk(0, 1, 2'b10, 0, 0, (i % 3) == 0,
                      (i < 3) ? 4'd0 : 4'(pp_seq[i / 3 - 1]),
                      ((i % 3) == 0) && ((i / 3) == 10 || (i / 3) == 19)));
    run_vq("pingpong");

    // Load mid-interval, saturating load, load coincident with tick.
    do_reset();
    vq.push_back(mk(0, 1, 2'b00, 0, 0,  0, 0, 0));
    vq.push_back(mk(0, 1, 2'b00, 0, 0,  0, 0, 0));
    vq.push_back(mk(0, 1, 2'b00, 0, 0,  1, 1, 0));
    vq.push_back(mk(0, 1, 2'b00, 1, 5,  0, 5, 0));
    vq.push_back(mk(0, 1, 2'b00, 0, 0,  0, 5, 0));
    vq.push_back(mk(0, 1, 2'b00, 0, 0,  0, 5, 0));
    vq.push_back(mk(0, 1, 2'b00, 0, 0,  1, 6, 0));
    vq.push_back(mk(0, 1, 2'b00, 1, 12, 0, 9, 0));
    vq.push_back(mk(0, 1, 2'b00, 0, 0,  0, 9, 0));
    vq.push_back(mk(0, 1, 2'b00, 0, 0,  0, 9, 0));
    vq.push_back(mk(0, 1, 2'b00, 0, 0,  1, 0, 1));
    vq.push_back(mk(0, 1, 2'b00, 0, 0,  0, 0, 0));
    vq.push_back(mk(0, 1, 2'b00, 0, 0,  0, 0, 0));
    vq.push_back(mk(0, 1, 2'b00, 1, 3,  1, 3, 0));
    vq.push_back(mk(0, 1, 2'b00, 0, 0,  0, 3, 0));
    vq.push_back(mk(0, 1, 2'b00, 0, 0,  0, 3, 0));
    vq.push_back(mk(0, 1, 2'b00, 0, 0,  1, 4, 0));
    run_vq("load");

    // Enable freeze at pre=1, then reset beating load and tick.
    do_reset();
    vq.push_back(mk(0, 1, 2'b00, 0, 0, 0, 0, 0));
    for (int i = 0; i < 7; i++) vq.push_back(mk(0, 0, 2'b00, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 2'b00, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 2'b00, 0, 0, 1, 1, 0));
    vq.push_back(mk(1, 1, 2'b00, 1, 7, 0, 0, 0));
    vq.push_back(mk(0, 1, 2'b00, 1, 4, 0, 4, 0));
    vq.push_back(mk(0, 1, 2'b00, 0, 0, 0, 4, 0));
    vq.push_back(mk(0, 1, 2'b00, 0, 0, 0, 4, 0));
    vq.push_back(mk(1, 1, 2'b00, 0, 0, 1, 0, 0));
    vq.push_back(mk(0, 1, 2'b00, 0, 0, 0, 0, 0));
    run_vq("enable");

    // Hold keeps ticking without stepping; up resumes and wraps from 9.
    do_reset();
    vq.push_back(mk(0, 1, 2'b00, 1, 9, 0, 9, 0));
    for (int i = 1; i <= 9; i++) vq.push_back(mk(0, 1, 2'b11, 0, 0, (i % 3) == 0, 9, 0));
    vq.push_back(mk(0, 1, 2'b00, 0, 0, 0, 9, 0));
    vq.push_back(mk(0, 1, 2'b00, 0, 0, 0, 9, 0));
    vq.push_back(mk(0, 1, 2'b00, 0, 0, 1, 0, 1));
    run_vq("hold");

    // Ping-pong entry at 9 turns immediately; re-entry after up forces dir=up.
    do_reset();
    vq.push_back(mk(0, 1, 2'b10, 1, 9, 0, 9, 0));
    vq.push_back(mk(0, 1, 2'b10, 0, 0, 0, 9, 0));
    vq.push_back(mk(0, 1, 2'b10, 0, 0, 0, 9, 0));
    vq.push_back(mk(0, 1, 2'b10, 0, 0, 1, 8, 1));
    vq.push_back(mk(0, 1, 2'b10, 0, 0, 0, 8, 0));
    vq.push_back(mk(0, 1, 2'b10, 0, 0, 0, 8, 0));
    vq.push_back(mk(0, 1, 2'b10, 0, 0, 1, 7, 0));
    vq.push_back(mk(0, 1, 2'b00, 0, 0, 0, 7, 0));
    vq.push_back(mk(0, 1, 2'b00, 0, 0, 0, 7, 0));
    vq.push_back(mk(0, 1, 2'b00, 0, 0, 1, 8, 0));
    vq.push_back(mk(0, 1, 2'b10, 0, 0, 0, 8, 0));
    vq.push_back(mk(0, 1, 2'b10, 0, 0, 0, 8, 0));
    vq.push_back(mk(0, 1, 2'b10, 0, 0, 1, 9, 0));
    vq.push_back(mk(0, 1, 2'b10, 0, 0, 0, 9, 0));
    vq.push_back(mk(0, 1, 2'b10, 0, 0, 0, 9, 0));
    vq.push_back(mk(0, 1, 2'b10, 0, 0, 1, 8, 1));
    vq.push_back(mk(0, 0, 2'b10, 1, 2, 0, 2, 0));
    run_vq("ppentry");

    // DIV=1, MODULUS=16: tick follows en, one step per enabled cycle.
    do_reset();
    en = 1'b0;
    en2 = 1'b1;
    #1;
    chk("div1 reset tick en=1", 32'(tick2), 32'd1);
    en2 = 1'b0;
    #1;
    chk("div1 reset tick en=0", 32'(tick2), 32'd0);
    for (int i = 1; i <= 18; i++) begin
      en2 = 1'b1;
      #1;
      chk($sformatf("div1[%0d] tick", i), 32'(tick2), 32'd1);
      @(posedge clk);
      #1;
      chk($sformatf("div1[%0d] cnt", i), 32'(cnt2), 32'(i % 16));
      chk($sformatf("div1[%0d] wrap", i), 32'(wrap2), 32'(i == 16));
      $display("div1[%0d] en=1 -> cnt=%0d wrap=%0b", i, cnt2, wrap2);
    end
    for (int i = 0; i < 2; i++) begin
      en2 = 1'b0;
      #1;
      chk($sformatf("div1 idle[%0d] tick", i), 32'(tick2), 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("div1 idle[%0d] cnt", i), 32'(cnt2), 32'd2);
      chk($sformatf("div1 idle[%0d] wrap", i), 32'(wrap2), 32'd0);
      $display("div1 idle[%0d] en=0 -> cnt=%0d wrap=%0b", i, cnt2, wrap2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
